// File: rtl/gf180mcu_osu_sc_12t_tbus_rx.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_12t_tbus_rx
//
// Receiving end of the shared single-wire tristate bus. The bus is sampled
// only on cycles where some driver holds its enable high (BUS_EN). Frames
// arrive MSB first and are collected into WIDTH-bit words. Each word is
// handed to the consumer through a one-entry valid/ready slot.
//
// Every frame must be followed by one idle turnaround cycle before the next
// frame starts. Short frames, long frames and a missing turnaround raise the
// sticky framing flag. A word that arrives while the slot is still full is
// dropped and raises the sticky overrun flag.
//
// Optional feature (compile-time macro TBUS_RX_PARITY_EN):
//   defined   - each frame carries WIDTH data bits followed by one even-parity
//               bit. A frame with bad parity sets PERR and is not delivered.
//   undefined - frames are exactly WIDTH bits and PERR is tied to 0.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RN       in   synchronous active-low reset
//   BUS      in   resolved bus wire, meaningful only while BUS_EN=1
//   BUS_EN   in   OR of all driver enables
//   DOUT     out  received word, held stable while DVALID=1
//   DVALID   out  output slot holds a word
//   DREADY   in   consumer accepts the word when DVALID&DREADY at an edge
//   BUS_Q    out  bus keeper, last bit sampled with BUS_EN=1
//   BUSY     out  receiver is inside a frame or its turnaround
//   FERR     out  sticky framing error
//   OVR      out  sticky overrun
//   PERR     out  sticky parity error
//   ERR_CLR  in   clears FERR, OVR and PERR (a same-cycle set still wins)
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_12t_tbus_rx #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             BUS,
   input  logic             BUS_EN,
   output logic [WIDTH-1:0] DOUT,
   output logic             DVALID,
   input  logic             DREADY,
   output logic             BUS_Q,
   output logic             BUSY,
   output logic             FERR,
   output logic             OVR,
   output logic             PERR,
   input  logic             ERR_CLR
);

`ifdef TBUS_RX_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   // The shift register only ever holds the bits before the last one; the
   // last bit is taken straight from BUS on the completion edge.
   localparam int SREG_W = FLEN - 1;
   localparam logic [5:0] LAST_CNT = 6'(FLEN - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [SREG_W-1:0] shift_q, shift_d;
   logic              long_q, long_d;
   logic              bus_q_q, bus_q_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              dvalid_q, dvalid_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;

   logic              frame_done;
   logic              ferr_set;
   logic              ovr_set;
   logic              load_ok;
   logic [WIDTH-1:0]  rx_word;

   // Frame sequencer. long_q remembers that the current turnaround has
   // already been violated so FERR is only raised on the first bad cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      long_d     = 1'b0;
      frame_done = 1'b0;
      ferr_set   = 1'b0;
      bus_q_d    = BUS_EN ? BUS : bus_q_q;
      case (state_q)
         ST_IDLE: begin
            if (BUS_EN) begin
               shift_d = SREG_W'(BUS);
               cnt_d   = 6'd1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (BUS_EN) begin
               if (cnt_q == LAST_CNT) begin
                  frame_done = 1'b1;
                  cnt_d      = 6'd0;
                  state_d    = ST_TURN;
               end else begin
                  shift_d = (shift_q << 1) | SREG_W'(BUS);
                  cnt_d   = cnt_q + 6'd1;
               end
            end else begin
               // Driver let go early: throw the partial word away.
               ferr_set = 1'b1;
               shift_d  = '0;
               cnt_d    = 6'd0;
               state_d  = ST_IDLE;
            end
         end
         ST_TURN: begin
            if (BUS_EN) begin
               long_d   = 1'b1;
               ferr_set = ~long_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef TBUS_RX_PARITY_EN
   logic perr_q, perr_d;
   logic par_ok;

   // Data sits in the shift register, BUS carries the parity bit.
   always_comb begin
      rx_word = shift_q;
      par_ok  = ~(^{shift_q, BUS});
      load_ok = frame_done & par_ok;
      perr_d  = (perr_q & ~ERR_CLR) | (frame_done & ~par_ok);
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign PERR = perr_q;
`else
   always_comb begin
      rx_word = {shift_q, BUS};
      load_ok = frame_done;
   end

   assign PERR = 1'b0;
`endif

   // Output slot. A load may coincide with an accept, in which case the slot
   // stays full with the new word; a load into a full, stalled slot is lost.
   always_comb begin
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      ovr_set  = 1'b0;
      if (load_ok) begin
         if (!dvalid_q || DREADY) begin
            dout_d   = rx_word;
            dvalid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (dvalid_q && DREADY) begin
         dvalid_d = 1'b0;
      end
      ferr_d = (ferr_q & ~ERR_CLR) | ferr_set;
      ovr_d  = (ovr_q & ~ERR_CLR) | ovr_set;
   end

   // State register; reset overrides everything including a frame in flight.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         shift_q  <= '0;
         long_q   <= 1'b0;
         bus_q_q  <= 1'b0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         long_q   <= long_d;
         bus_q_q  <= bus_q_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign DOUT   = dout_q;
   assign DVALID = dvalid_q;
   assign BUS_Q  = bus_q_q;
   assign BUSY   = (state_q != ST_IDLE);
   assign FERR   = ferr_q;
   assign OVR    = ovr_q;

endmodule
